// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types for the physical-register free list.
package rename_pkg;
  localparam int PRF_WIDTH = 6;
  localparam int ARCH_REGS = 32;
  localparam int LANES     = 4;
  localparam int PRF_DEPTH = 1 << PRF_WIDTH;

  typedef logic [PRF_WIDTH-1:0] preg_t;
  typedef logic [PRF_WIDTH:0]   fl_ptr_t;
endpackage

// File: rtl/prf_free_list_lane_offset.sv
// fl_lane_offset: compacts a 4-lane mask into per-lane slot offsets plus a lane count.
module fl_lane_offset
  import rename_pkg::*;
(
  input  logic [LANES-1:0]   mask,
  output logic [2*LANES-1:0] offset,
  output logic [2:0]         cnt
);
  // prefix[i] = number of set mask bits strictly below lane i
  logic [2:0] prefix [LANES+1];

  assign prefix[0] = 3'd0;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign prefix[gi+1]         = prefix[gi] + {2'b00, mask[gi]};
      assign offset[2*gi +: 2]    = prefix[gi][1:0];
    end
  endgenerate

  assign cnt = prefix[LANES];
endmodule

// File: rtl/prf_free_list.sv
// prf_free_list: 4-wide circular free list of physical registers for rename.
// Optional FREELIST_RECOVER_EN adds a flush port that rewinds head to the commit point.
module prf_free_list
  import rename_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
`ifdef FREELIST_RECOVER_EN
  input  logic                 flush,
`endif
  input  logic [LANES-1:0]     alloc_req,
  output logic                 alloc_ready,
  output preg_t                alloc_preg0,
  output preg_t                alloc_preg1,
  output preg_t                alloc_preg2,
  output preg_t                alloc_preg3,
  input  logic [LANES-1:0]     rel_valid,
  input  preg_t                rel_preg0,
  input  preg_t                rel_preg1,
  input  preg_t                rel_preg2,
  input  preg_t                rel_preg3,
  output logic [PRF_WIDTH:0]   free_cnt,
  output logic                 err_overflow
);
  localparam fl_ptr_t              RESET_TAIL = fl_ptr_t'(ARCH_REGS);
  localparam logic [PRF_WIDTH:0]   MIN_READY  = (PRF_WIDTH+1)'(LANES);
  localparam logic [PRF_WIDTH+1:0] CAPACITY   = (PRF_WIDTH+2)'(PRF_DEPTH);

  preg_t mem [PRF_DEPTH];

  fl_ptr_t            head_reg, head_next, tail_reg, tail_next;
  logic [PRF_WIDTH:0] cnt_reg, cnt_next, nalloc, nrel;
  logic               err_reg, alloc_fire, overflow, rel_ok;

  logic [2*LANES-1:0] alloc_off, rel_off;
  logic [2:0]         alloc_cnt, rel_cnt;
  preg_t              rel_preg   [LANES];
  preg_t              alloc_preg [LANES];

  fl_lane_offset u_alloc_off (.mask(alloc_req), .offset(alloc_off), .cnt(alloc_cnt));
  fl_lane_offset u_rel_off   (.mask(rel_valid), .offset(rel_off),   .cnt(rel_cnt));

  assign rel_preg[0] = rel_preg0;
  assign rel_preg[1] = rel_preg1;
  assign rel_preg[2] = rel_preg2;
  assign rel_preg[3] = rel_preg3;

  // Same-cycle read; released entries land beyond tail so they never alias the read window
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_read
      assign alloc_preg[gi] = mem[head_reg[PRF_WIDTH-1:0] + preg_t'(alloc_off[2*gi +: 2])];
    end
  endgenerate

  assign alloc_preg0  = alloc_preg[0];
  assign alloc_preg1  = alloc_preg[1];
  assign alloc_preg2  = alloc_preg[2];
  assign alloc_preg3  = alloc_preg[3];
  assign alloc_ready  = (cnt_reg >= MIN_READY);
  assign free_cnt     = cnt_reg;
  assign err_overflow = err_reg;

  // A release group that would exceed capacity is dropped whole
  assign overflow = ({1'b0, cnt_reg} + (PRF_WIDTH+2)'(rel_cnt)) > CAPACITY;
  assign rel_ok   = !overflow;
  assign nrel     = rel_ok ? (PRF_WIDTH+1)'(rel_cnt) : '0;

`ifdef FREELIST_RECOVER_EN
  fl_ptr_t commit_head_reg, commit_head_next;
`endif

  always_comb begin
    alloc_fire = alloc_ready && (|alloc_req);
`ifdef FREELIST_RECOVER_EN
    if (flush) alloc_fire = 1'b0;
`endif
    nalloc    = alloc_fire ? (PRF_WIDTH+1)'(alloc_cnt) : '0;
    head_next = head_reg + nalloc;
    tail_next = tail_reg + nrel;
    cnt_next  = cnt_reg - nalloc + nrel;
`ifdef FREELIST_RECOVER_EN
    commit_head_next = commit_head_reg + nrel;
    if (flush) begin
      head_next = commit_head_next;
      cnt_next  = tail_next - commit_head_next;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= RESET_TAIL;
      cnt_reg  <= (PRF_WIDTH+1)'(ARCH_REGS);
      err_reg  <= 1'b0;
      for (int i = 0; i < ARCH_REGS; i++) begin
        mem[preg_t'(i)] <= preg_t'(ARCH_REGS + i);
      end
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      cnt_reg  <= cnt_next;
      err_reg  <= err_reg | overflow;
      for (int l = 0; l < LANES; l++) begin
        if (rel_valid[l] && rel_ok) begin
          mem[tail_reg[PRF_WIDTH-1:0] + preg_t'(rel_off[2*l +: 2])] <= rel_preg[l];
        end
      end
    end
  end

`ifdef FREELIST_RECOVER_EN
  always_ff @(posedge clk) begin
    if (rst) commit_head_reg <= '0;
    else     commit_head_reg <= commit_head_next;
  end
`endif
endmodule

// File: tb/tb_prf_free_list.sv
// Scoreboard bench for prf_free_list: queue-based free-list model, random and directed traffic.
module tb_prf_free_list;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alloc_req = '0;
  logic       alloc_ready;
  logic [5:0] alloc_preg0, alloc_preg1, alloc_preg2, alloc_preg3;
  logic [3:0] rel_valid = '0;
  logic [5:0] rel_preg0 = '0, rel_preg1 = '0, rel_preg2 = '0, rel_preg3 = '0;
  logic [6:0] free_cnt;
  logic       err_overflow;
`ifdef FREELIST_RECOVER_EN
  logic       flush = 1'b0;
`endif

  always #5 clk = ~clk;

  prf_free_list dut (
    .clk(clk), .rst(rst),
`ifdef FREELIST_RECOVER_EN
    .flush(flush),
`endif
    .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_preg0(alloc_preg0), .alloc_preg1(alloc_preg1),
    .alloc_preg2(alloc_preg2), .alloc_preg3(alloc_preg3),
    .rel_valid(rel_valid),
    .rel_preg0(rel_preg0), .rel_preg1(rel_preg1),
    .rel_preg2(rel_preg2), .rel_preg3(rel_preg3),
    .free_cnt(free_cnt), .err_overflow(err_overflow)
  );

  typedef struct {
    logic        rdy;
    logic [3:0]  req;
    logic [23:0] g;
    int          cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   free_q[$];   // free pregs in allocation order
  int   spec_q[$];   // allocated pregs not yet retired, oldest first
  bit   err_m;
  int   total = 0;
  int   bad = 0;
  int   txn = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    free_q.delete();
    spec_q.delete();
    for (int p = 32; p < 64; p++) free_q.push_back(p);
    err_m = 1'b0;
  endfunction

  // Drive one cycle of stimulus, queue the expected view, then advance the model.
  task automatic cycle(input logic [3:0] req, input logic [3:0] rv, input logic [23:0] rp,
                       input bit do_rst, input bit do_flush);
    exp_t e;
    int   k;
    int   nrel;
    @(posedge clk);
    #1;
    alloc_req = req;
    rel_valid = rv;
    {rel_preg3, rel_preg2, rel_preg1, rel_preg0} = rp;
    rst = do_rst;
`ifdef FREELIST_RECOVER_EN
    flush = do_flush;
`endif
    e.rdy = (free_q.size() >= 4);
    e.req = req;
    e.g   = '0;
    e.cnt = free_q.size();
    e.err = err_m;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && e.rdy) begin
        e.g[6*i +: 6] = 6'(free_q[k]);
        k++;
      end
    end
    exp_q.push_back(e);

    if (do_rst) begin
      model_reset();
    end else begin
      nrel = $countones(rv);
      if (free_q.size() + nrel > 64) begin
        err_m = 1'b1;
        nrel = 0;
      end
      if (e.rdy && req != 0 && !do_flush) begin
        for (int i = 0; i < k; i++) spec_q.push_back(free_q.pop_front());
      end
      if (nrel > 0) begin
        for (int i = 0; i < 4; i++) if (rv[i]) free_q.push_back(int'(rp[6*i +: 6]));
        for (int i = 0; i < nrel; i++) if (spec_q.size() > 0) void'(spec_q.pop_front());
      end
      if (do_flush) begin
        free_q = {spec_q, free_q};
        spec_q.delete();
      end
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    logic [23:0] g_act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g_act = {alloc_preg3, alloc_preg2, alloc_preg1, alloc_preg0};
        txn++;
        $display("txn %0d req=%b rdy=%0b cnt=%0d err=%0b grants=%h", txn, e.req,
                 alloc_ready, free_cnt, err_overflow, g_act);
        chk("alloc_ready", 32'(alloc_ready), 32'(e.rdy));
        chk("free_cnt", 32'(free_cnt), 32'(e.cnt));
        chk("err_overflow", 32'(err_overflow), 32'(e.err));
        for (int i = 0; i < 4; i++) begin
          if (e.req[i] && e.rdy)
            chk($sformatf("grant%0d", i), 32'(g_act[6*i +: 6]), 32'(e.g[6*i +: 6]));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);

    // first group after reset grants 32..35
    cycle(4'b1111, 4'b0000, '0, 0, 0);
    #2;
    chk("first_grant0", 32'(alloc_preg0), 32'd32);
    chk("first_grant3", 32'(alloc_preg3), 32'd35);
    cycle(4'b0000, 4'b0000, '0, 0, 0);
    #2;
    chk("cnt_after_first", 32'(free_cnt), 32'd28);
    chk("second_grant0", 32'(alloc_preg0), 32'd36);

    // drain to 4, then to 0
    repeat (6) cycle(4'b1111, 4'b0000, '0, 0, 0);
    cycle(4'b0000, 4'b0000, '0, 0, 0);
    #2;
    chk("cnt_at_4", 32'(free_cnt), 32'd4);
    chk("ready_at_4", 32'(alloc_ready), 32'd1);
    cycle(4'b1111, 4'b0000, '0, 0, 0);
    repeat (2) cycle(4'b1111, 4'b0000, '0, 0, 0);
    #2;
    chk("ready_at_0", 32'(alloc_ready), 32'd0);
    chk("cnt_held_0", 32'(free_cnt), 32'd0);

    // release 5,9,12 on lanes 0,1,3, then 7
    cycle(4'b0000, 4'b1011, {6'd12, 6'd0, 6'd9, 6'd5}, 0, 0);
    cycle(4'b0000, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd7}, 0, 0);
    #2;
    chk("cnt_at_3", 32'(free_cnt), 32'd3);
    chk("ready_at_3", 32'(alloc_ready), 32'd0);
    cycle(4'b1111, 4'b0000, '0, 0, 0);
    #2;
    chk("regrant", 32'({alloc_preg3, alloc_preg2, alloc_preg1, alloc_preg0}),
        32'({6'd7, 6'd12, 6'd9, 6'd5}));

    // build up to 10 then mixed allocate/release
    repeat (2) cycle(4'b0000, 4'b1111, {6'd20, 6'd21, 6'd22, 6'd23}, 0, 0);
    cycle(4'b0000, 4'b0011, {6'd0, 6'd0, 6'd24, 6'd25}, 0, 0);
    cycle(4'b0101, 4'b0011, {6'd0, 6'd0, 6'd26, 6'd27}, 0, 0);
    cycle(4'b0000, 4'b0000, '0, 0, 0);
    #2;
    chk("cnt_mixed", 32'(free_cnt), 32'd10);

    // push to 62, then an overflowing group
    repeat (13) cycle(4'b0000, 4'b1111, {6'd1, 6'd2, 6'd3, 6'd4}, 0, 0);
    cycle(4'b0000, 4'b1111, {6'd11, 6'd12, 6'd13, 6'd14}, 0, 0);
    repeat (2) cycle(4'b0000, 4'b0000, '0, 0, 0);
    #2;
    chk("ovf_err", 32'(err_overflow), 32'd1);
    chk("ovf_cnt", 32'(free_cnt), 32'd62);

    // reset mid-operation with traffic present
    cycle(4'b1111, 4'b1111, {6'd1, 6'd2, 6'd3, 6'd4}, 1, 0);
    cycle(4'b0000, 4'b0000, '0, 0, 0);
    #2;
    chk("rst_cnt", 32'(free_cnt), 32'd32);
    chk("rst_err", 32'(err_overflow), 32'd0);

`ifdef FREELIST_RECOVER_EN
    repeat (2) cycle(4'b1111, 4'b0000, '0, 0, 0);
    cycle(4'b0000, 4'b0011, {6'd0, 6'd0, 6'd41, 6'd40}, 0, 0);
    cycle(4'b1111, 4'b0000, '0, 0, 1);
    cycle(4'b0000, 4'b0000, '0, 0, 0);
    #2;
    chk("flush_cnt", 32'(free_cnt), 32'd32);
    chk("flush_grant", 32'(alloc_preg0), 32'd34);
`endif

    // randomized traffic with occasional reset
    for (int n = 0; n < 2000; n++) begin
      logic [3:0]  rq, rv;
      logic [23:0] rp;
      rq = 4'($urandom_range(0, 15));
      rv = 4'($urandom_range(0, 15));
      rp = 24'($urandom);
      cycle(rq, rv, rp, ($urandom_range(0, 499) == 0), 0);
    end
    cycle(4'b0000, 4'b0000, '0, 0, 0);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
